key_board_controler: RTL and testbench
======================================

KEY_BOARD_CONTROLER -- requirements
Module: key_board_controler

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal PS2C samples required to change the filtered clock level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle cycles (1 ms at 50 MHz) after which a partial frame is abandoned.
REQ-003 SHALL have port clk, input, 1 bit: single clock (50 MHz system clock); all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port PS2C, input, 1 bit: PS/2 clock from the keyboard, asynchronous.
REQ-006 SHALL have port PS2D, input, 1 bit: PS/2 data from the keyboard, asynchronous.
REQ-007 SHALL have port InteAccept, input, 1 bit: CPU acknowledge of the pending keyboard interrupt.
REQ-008 SHALL have port scanCode, output, 16 bits: {prefix byte, code byte} of the last complete key event.
REQ-009 SHALL have port KeyBoardInte, output, 1 bit: level interrupt request; high while a new scanCode is unacknowledged.

Function
REQ-010 SHALL pass PS2C and PS2D through 2-flop synchronizers before any use.
REQ-011 SHALL change the filtered PS2C level only after FILTER_LEN consecutive identical synchronized samples.
REQ-012 SHALL sample synchronized PS2D on each filtered-PS2C falling edge.
REQ-013 SHALL receive 11-bit frames: start=0, 8 data bits LSB first, odd parity, stop=1.
REQ-014 SHALL discard a frame whose start bit is 1 without advancing the bit counter; the next falling edge is treated as a new start bit.
REQ-015 SHALL discard a frame whose stop bit is 0, with no output change.
REQ-016 SHALL clear the bit counter and drop the partial frame when TIMEOUT_CYCLES clocks pass with no filtered falling edge mid-frame.
REQ-017 SHALL hold a byte of 8'hE0 or 8'hF0 in an internal prefix register, with no scanCode or interrupt update; a later prefix byte overwrites the earlier one.
REQ-018 SHALL, on a valid non-prefix byte B, load scanCode <= {prefix, B}, clear prefix to 8'h00, and set KeyBoardInte, all on the clock edge after the stop-bit falling edge is detected.
REQ-019 SHALL clear KeyBoardInte on a rising clk edge where InteAccept=1 and no new code completes in the same cycle.
REQ-020 SHALL, when a new code completes in the same cycle as InteAccept=1, keep KeyBoardInte=1 and load the new scanCode (new event wins).
REQ-021 SHALL, when a new code completes while KeyBoardInte is already 1, overwrite scanCode, keep KeyBoardInte=1, and keep no overrun indication.
REQ-022 SHALL hold scanCode stable between completed codes, independent of InteAccept.
REQ-023 SHALL ignore InteAccept while KeyBoardInte=0.

Reset
REQ-024 SHALL, on rst=1 at a rising clk edge, set scanCode=16'h0000, KeyBoardInte=0, prefix=8'h00, and the bit counter, filter and timeout counters to idle.
REQ-025 SHALL abandon any frame in progress when rst is asserted mid-frame; reception resumes at the next start bit after rst deasserts.
REQ-026 SHALL give rst priority over frame completion and InteAccept in the same cycle.

Configuration
REQ-027 SHALL, with macro KBD_PARITY_CHECK_EN defined, discard frames whose 9 data+parity bits have even parity, with no output change.
REQ-028 SHALL, without KBD_PARITY_CHECK_EN, ignore the parity bit and accept the frame when the start and stop bits are valid.

Verification
REQ-029 SHALL cover: frame byte 8'h1C with correct parity, after reset -> scanCode=16'h001C and KeyBoardInte=1 one clk after the stop edge.
REQ-030 SHALL cover: frames F0 then 1C -> no interrupt after F0; after 1C, scanCode=16'hF01C and KeyBoardInte=1.
REQ-031 SHALL cover: InteAccept pulse 1 cycle while pending -> KeyBoardInte=0 next cycle, scanCode unchanged at 16'hF01C.
REQ-032 SHALL cover: byte 8'h1C with wrong parity, KBD_PARITY_CHECK_EN defined -> scanCode and KeyBoardInte unchanged; with the macro undefined -> scanCode=16'h001C.
REQ-033 SHALL cover: 5 bits sent, then idle for 50000 cycles, then a full 8'h32 frame -> scanCode=16'h0032, single interrupt.
REQ-034 SHALL cover: InteAccept=1 in the completion cycle of 8'h29 -> KeyBoardInte stays 1 and scanCode=16'h0029; rst mid-frame -> outputs 0, no interrupt.

Source files
------------

// File: rtl/key_board_controler.sv
// rtl/key_board_controler.sv - PS/2 keyboard receiver with prefix capture and level interrupt
// Optional parity checking is enabled by defining KBD_PARITY_CHECK_EN.
module key_board_controler #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PS2C,
    input  logic        PS2D,
    input  logic        InteAccept,
    output logic [15:0] scanCode,
    output logic        KeyBoardInte
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic [FW-1:0] filt_cnt;
    logic          filt_level;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    prefix;
    logic          parity_ok;
    logic          frame_ok;
    logic          is_prefix;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], PS2C};
            d_sync <= {d_sync[0], PS2D};
        end
    end

    // Level flips only after FILTER_LEN consecutive samples disagree with it;
    // fall is a one-cycle pulse following a 1->0 flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            fall       <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (c_sync[1] == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_level <= c_sync[1];
                filt_cnt   <= '0;
                fall       <= filt_level;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

`ifdef KBD_PARITY_CHECK_EN
    logic par_bit;
    assign parity_ok = ^{shreg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            idle_cnt <= '0;
`ifdef KBD_PARITY_CHECK_EN
            par_bit  <= 1'b0;
`endif
        end else if (fall) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'd0) begin
                if (!d_sync[1]) bit_cnt <= 4'd1;
            end else if (bit_cnt <= 4'd8) begin
                shreg   <= {d_sync[1], shreg[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
`ifdef KBD_PARITY_CHECK_EN
                par_bit <= d_sync[1];
`endif
                bit_cnt <= 4'd10;
            end else begin
                bit_cnt <= 4'd0;
            end
        end else if (bit_cnt != 4'd0) begin
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end else begin
            idle_cnt <= '0;
        end
    end

    assign frame_ok  = fall && (bit_cnt == 4'd10) && d_sync[1] && parity_ok;
    assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);

    // A completing non-prefix code outranks InteAccept in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            scanCode     <= 16'h0000;
            KeyBoardInte <= 1'b0;
            prefix       <= 8'h00;
        end else if (frame_ok && !is_prefix) begin
            scanCode     <= {prefix, shreg};
            prefix       <= 8'h00;
            KeyBoardInte <= 1'b1;
        end else begin
            if (frame_ok) prefix <= shreg;
            if (InteAccept) KeyBoardInte <= 1'b0;
        end
    end
endmodule

// File: tb/tb_key_board_controler.sv
// tb/tb_key_board_controler.sv - randomized directed bench with a key-event reference model
module tb_key_board_controler;
    localparam int HALF = 40;
`ifdef KBD_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PS2C = 1'b1;
    logic        PS2D = 1'b1;
    logic        InteAccept = 1'b0;
    logic [15:0] scanCode;
    logic        KeyBoardInte;

    int checks = 0;
    int failures = 0;
    bit glitch_en = 1'b0;

    logic [15:0] m_scan = 16'h0000;
    logic        m_inte = 1'b0;
    logic [7:0]  m_prefix = 8'h00;

    key_board_controler dut (
        .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D),
        .InteAccept(InteAccept), .scanCode(scanCode), .KeyBoardInte(KeyBoardInte)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_scan"}, {16'h0, scanCode}, {16'h0, m_scan});
        check({tag, "_inte"}, {31'h0, KeyBoardInte}, {31'h0, m_inte});
    endtask

    task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        if (stop_ok && (par_ok || !PAR_EN)) begin
            if (b == 8'hE0 || b == 8'hF0) begin
                m_prefix = b;
            end else begin
                m_scan   = {m_prefix, b};
                m_prefix = 8'h00;
                m_inte   = 1'b1;
            end
        end
    endtask

    task automatic send_bit(input logic d);
        @(negedge clk) PS2D = d;
        repeat (HALF) @(negedge clk);
        PS2C = 1'b0;
        repeat (HALF) @(negedge clk);
        PS2C = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        if (glitch_en && ($urandom % 3 == 0)) begin
            PS2C = 1'b0;
            repeat (3) @(negedge clk);
            PS2C = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    endtask

    task automatic full_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_frame(b, bad_par, bad_stop, 11);
        model_frame(b, !bad_par, !bad_stop);
    endtask

    task automatic accept_pulse();
        @(negedge clk) InteAccept = 1'b1;
        @(negedge clk) InteAccept = 1'b0;
        m_inte = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        bit bp, bs, found;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset");

        // First code after reset; interrupt must still be low before the stop bit.
        send_frame(8'h1C, 1'b0, 1'b0, 10);
        check("pre_stop_inte", {31'h0, KeyBoardInte}, 32'h0);
        send_bit(1'b1);
        model_frame(8'h1C, 1'b1, 1'b1);
        check("first_code", {16'h0, scanCode}, 32'h001C);
        check_outputs("first_code");

        accept_pulse();
        check_outputs("accept1");

        full_frame(8'hF0, 1'b0, 1'b0);
        check("after_prefix_inte", {31'h0, KeyBoardInte}, 32'h0);
        full_frame(8'h1C, 1'b0, 1'b0);
        check("break_code", {16'h0, scanCode}, 32'hF01C);
        check_outputs("break_code");

        accept_pulse();
        check("accept2_scan", {16'h0, scanCode}, 32'hF01C);
        check_outputs("accept2");

        full_frame(8'h1C, 1'b1, 1'b0);
        check_outputs("bad_parity");
        if (KeyBoardInte) accept_pulse();

        // Partial frame abandoned by idle timeout, then a clean frame.
        send_frame(8'h55, 1'b0, 1'b0, 5);
        repeat (50100) @(negedge clk);
        full_frame(8'h32, 1'b0, 1'b0);
        check("timeout_recover", {16'h0, scanCode}, 32'h0032);
        check_outputs("timeout_recover");

        full_frame(8'h6B, 1'b0, 1'b1);
        check_outputs("bad_stop");

        accept_pulse();
        accept_pulse();
        check_outputs("accept_idle");

        // InteAccept held through the completion cycle of 8'h29.
        send_frame(8'h29, 1'b0, 1'b0, 10);
        @(negedge clk) PS2D = 1'b1;
        repeat (HALF) @(negedge clk);
        PS2C = 1'b0;
        InteAccept = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (scanCode == 16'h0029) found = 1'b1;
        end
        InteAccept = 1'b0;
        check("accept_race_seen", {31'h0, found}, 32'h1);
        model_frame(8'h29, 1'b1, 1'b1);
        check_outputs("accept_race");
        repeat (HALF) @(negedge clk);
        PS2C = 1'b1;
        repeat (HALF) @(negedge clk);

        // Reset in the middle of a frame.
        send_frame(8'hA5, 1'b0, 1'b0, 5);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_scan = 16'h0000; m_inte = 1'b0; m_prefix = 8'h00;
        check_outputs("mid_reset");
        full_frame(8'h5A, 1'b0, 1'b0);
        check_outputs("post_reset");

        glitch_en = 1'b1;
        for (int n = 0; n < 14; n++) begin
            case ($urandom % 5)
                0: b = ($urandom % 2) ? 8'hE0 : 8'hF0;
                default: b = 8'($urandom);
            endcase
            bp = ($urandom % 7 == 0);
            bs = ($urandom % 9 == 0);
            full_frame(b, bp, bs);
            check_outputs("rand_frame");
            if ($urandom % 2) begin
                accept_pulse();
                check_outputs("rand_accept");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
